bt_multilink_clk: RTL and testbench
===================================

Name: bt_multilink_clk

Overview:
- Parametrised Bluetooth clock and timebase generator for NLINK concurrent links; each link has an independently resynchronisable slot timebase.
- Per link it produces CLK (native plus offset), TX/RX slot-end strobes, a receive uncertainty window and link-loss supervision.
- Sits between the 6 MHz clock domain root and the per-link baseband controllers, hop-kernel and correlators.

Parameters:
- NLINK, 2, number of independent link timebases.
- DIV_1US, 6, clk_6M cycles per 1 us tick.
- SLOT_US, 625, slot length in us.
- SYNC_US, 68, us position at which a correlated sync word asserts sync_p (window-close reference).
- WINW, 9, uncertainty window size width.
- SUPW, 16, supervision counter width (slots).

Ports:
- clk_6M  in  1  system clock, 6 MHz.
- rstz  in  1  asynchronous active-low reset.
- link_en  in  NLINK  per-link enable; 0 holds that link in reset state.
- link_offset  in  NLINK*28  per-link CLK offset added to CLKN (bits [1:0] ignored).
- sync_p  in  NLINK  per-link sync-word correlation pulse, 1 cycle.
- win_size  in  NLINK*WINW  per-link half-width of uncertainty window, us.
- sup_limit  in  NLINK*SUPW  slots without sync before link_lost; 0 disables supervision.
- p_1us  out  1  1-cycle tick every DIV_1US cycles.
- clkn  out  28  native clock: bit0 toggles every half slot.
- link_clk  out  NLINK*28  per-link CLK.
- us_cnt  out  NLINK*10  per-link us-in-slot counter, 0..SLOT_US-1.
- tx_endp  out  NLINK  end of a slot with link_clk[1]=0.
- rx_endp  out  NLINK  end of a slot with link_clk[1]=1.
- rx_win  out  NLINK  receive uncertainty window.
- rx_win_endp  out  NLINK  1-cycle pulse at window close.
- link_lost  out  NLINK  sticky supervision timeout flag.

Behaviour:
- Reset: all outputs 0; all counters 0. Reset is rstz asynchronous active-low on clock clk_6M.
- Tick: div counter 0..DIV_1US-1; p_1us=1 when count==DIV_1US-1; the counter then wraps to 0.
- Native slot: the native us counter advances on p_1us and wraps at SLOT_US-1.
  - clkn[0]=1 while native us >= SLOT_US/2 (integer division).
  - clkn[27:1] increments on native wrap; the 28-bit value wraps modulo 2^28.
- Per link i, counter update:
  - link_en=0: us_cnt=0, slot count=0, rx_win=0, link_lost=0, supervision=0.
  - Otherwise its own us counter and slot count advance as for the native timebase.
  - link_clk = {slot,half} + {link_offset[27:2],2'b00}, 28-bit modulo.
- Resync: sync_p[i] loads us_cnt with SYNC_US+1 on the next edge; slot count is unchanged.
  - If sync_p coincides with p_1us, the load wins and no increment occurs.
- Strobes: tx_endp/rx_endp assert in the same cycle as p_1us when us_cnt==SLOT_US-1, qualified by link_clk[1] before the increment.
- Window FSM per link: states CLOSED, OPEN, FORCED.
  - FORCED is entered whenever win_size > SLOT_US/2; rx_win=1 in FORCED; it returns to CLOSED once win_size <= SLOT_US/2.
  - CLOSED->OPEN on p_1us when us_cnt==SLOT_US-1-win_size and link_clk[1]==0 (the slot preceding an RX slot).
  - OPEN->CLOSED on p_1us when us_cnt==SYNC_US+win_size, or on sync_p (early close).
  - rx_win_endp pulses on either OPEN->CLOSED transition. It does not pulse on exit from FORCED.
  - A sync_p outside the window is still applied, and the window does not open.
- Supervision:
  - sup counter increments on each rx_endp.
  - Cleared on sync_p; sync_p wins if it coincides with an increment.
  - When the counter reaches sup_limit (nonzero), link_lost is set and the counter saturates.
  - link_lost clears only on sync_p or link_en=0.
- Mid-operation link_en drop: that link returns to reset state within 1 cycle; other links are unaffected.

Decomposition:
- Package bt_clk_pkg: SLOT_US, SYNC_US, CLKW=28, window state enum (CLOSED/OPEN/FORCED), and a helper for half-slot.
- One sub-module bt_link_timebase, instantiated NLINK times via generate.
  - It contains the us/slot counters, offset add, strobes, window FSM and supervision.
  - The top holds the 1 us divider and the native timebase.

Test Plan:
- Reset, 2 links enabled, offsets 0 -> p_1us every 6 cycles; clkn[0] rises at native us 312; clkn=2 after 625 us; link_clk equals clkn.
- link_offset[0]=28'h10 -> link_clk[0]=clkn+0x10; tx_endp[0]/rx_endp[0] alternate every 625 us.
- win_size=20; no sync -> rx_win rises at us_cnt 604 of the TX slot, falls at us 88 with a 1-cycle rx_win_endp.
- sync_p at us 50 inside the window -> us_cnt=69 next edge, rx_win closes with rx_win_endp; sup counter=0.
- sync_p coincident with p_1us -> us_cnt=69, not 70.
- win_size=400 -> rx_win constantly 1.
- sup_limit=3, no sync -> link_lost=1 at the 3rd rx_endp; a later sync_p clears it.
- Drop link_en[1] mid-window -> link 1 outputs 0 within 1 cycle; link 0 timing unchanged.

Source files
------------

// File: rtl/bt_clk_pkg.sv
// Shared constants, window state encoding and half-slot helper for the Bluetooth timebase.
package bt_clk_pkg;

    localparam int unsigned SLOT_US = 625;
    localparam int unsigned SYNC_US = 68;
    localparam int unsigned CLKW    = 28;
    localparam int unsigned USW     = 10;

    typedef enum logic [1:0] {
        WinClosed,
        WinOpen,
        WinForced
    } win_state_e;

    // CLK bit0: set during the second half of a slot
    function automatic logic half_slot(input logic [USW-1:0] us, input int unsigned slot_us);
        return 32'(us) >= slot_us / 2;
    endfunction

endpackage

// File: rtl/bt_multilink_clk_if.sv
// Per-link control inputs and timebase outputs between the clock generator and link controllers.
interface bt_multilink_clk_if #(
    parameter int unsigned NLINK = 2,
    parameter int unsigned WINW  = 9,
    parameter int unsigned SUPW  = 16
);
    import bt_clk_pkg::*;

    logic [NLINK-1:0]      link_en;
    logic [NLINK*CLKW-1:0] link_offset;
    logic [NLINK-1:0]      sync_p;
    logic [NLINK*WINW-1:0] win_size;
    logic [NLINK*SUPW-1:0] sup_limit;

    logic                  p_1us;
    logic [CLKW-1:0]       clkn;
    logic [NLINK*CLKW-1:0] link_clk;
    logic [NLINK*USW-1:0]  us_cnt;
    logic [NLINK-1:0]      tx_endp;
    logic [NLINK-1:0]      rx_endp;
    logic [NLINK-1:0]      rx_win;
    logic [NLINK-1:0]      rx_win_endp;
    logic [NLINK-1:0]      link_lost;

    modport master (
        output link_en, link_offset, sync_p, win_size, sup_limit,
        input  p_1us, clkn, link_clk, us_cnt, tx_endp, rx_endp, rx_win, rx_win_endp, link_lost
    );

    modport slave (
        input  link_en, link_offset, sync_p, win_size, sup_limit,
        output p_1us, clkn, link_clk, us_cnt, tx_endp, rx_endp, rx_win, rx_win_endp, link_lost
    );

endinterface

// File: rtl/bt_link_timebase.sv
// One link's resynchronisable slot timebase: CLK, slot strobes, RX window and supervision.
module bt_link_timebase
    import bt_clk_pkg::*;
#(
    parameter int unsigned SLOT_US = bt_clk_pkg::SLOT_US,
    parameter int unsigned SYNC_US = bt_clk_pkg::SYNC_US,
    parameter int unsigned WINW    = 9,
    parameter int unsigned SUPW    = 16
) (
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic            p_1us_i,
    input  logic            link_en_i,
    input  logic [CLKW-1:0] offset_i,
    input  logic            sync_p_i,
    input  logic [WINW-1:0] win_size_i,
    input  logic [SUPW-1:0] sup_limit_i,
    output logic [CLKW-1:0] link_clk_o,
    output logic [USW-1:0]  us_cnt_o,
    output logic            tx_endp_o,
    output logic            rx_endp_o,
    output logic            rx_win_o,
    output logic            rx_win_endp_o,
    output logic            link_lost_o
);

    localparam logic [USW-1:0]  LastUs   = USW'(SLOT_US - 1);
    localparam logic [USW-1:0]  SyncUs   = USW'(SYNC_US);
    localparam logic [USW-1:0]  SyncLoad = USW'(SYNC_US + 1);
    localparam logic [WINW-1:0] HalfSlot = WINW'(SLOT_US / 2);
    localparam logic [CLKW-1:0] OffMask  = ~CLKW'(3);

    logic            en_q;
    logic [USW-1:0]  us_q, us_d;
    logic [CLKW-2:0] slot_q, slot_d;
    logic [SUPW-1:0] sup_q, sup_d;
    logic            lost_q, lost_d;
    win_state_e      win_q, win_d;
    logic [CLKW-1:0] clk_sum;
    logic [USW-1:0]  win_ext;
    logic            slot_end;
    logic            sup_sat;

    assign clk_sum  = {slot_q, half_slot(us_q, SLOT_US)} + (offset_i & OffMask);
    assign win_ext  = USW'(win_size_i);
    assign slot_end = p_1us_i && (us_q == LastUs);
    assign sup_sat  = (sup_limit_i != '0) && (sup_q >= sup_limit_i);

    assign link_clk_o  = en_q ? clk_sum : '0;
    assign us_cnt_o    = us_q;
    assign tx_endp_o   = slot_end && !clk_sum[1];
    assign rx_endp_o   = slot_end && clk_sum[1];
    assign rx_win_o    = (win_q == WinOpen) || (win_q == WinForced);
    assign link_lost_o = lost_q;

    always_comb begin
        us_d   = us_q;
        slot_d = slot_q;
        if (!link_en_i) begin
            us_d   = '0;
            slot_d = '0;
        end else if (sync_p_i) begin
            us_d = SyncLoad;
        end else if (p_1us_i) begin
            if (us_q == LastUs) begin
                us_d   = '0;
                slot_d = slot_q + (CLKW-1)'(1);
            end else begin
                us_d = us_q + USW'(1);
            end
        end
    end

    always_comb begin
        sup_d  = sup_q;
        lost_d = lost_q;
        if (!link_en_i) begin
            sup_d  = '0;
            lost_d = 1'b0;
        end else begin
            if (sync_p_i) begin
                sup_d = '0;
            end else if (rx_endp_o && !sup_sat) begin
                sup_d = sup_q + SUPW'(1);
            end
            lost_d = !sync_p_i && (lost_q || ((sup_limit_i != '0) && (sup_d >= sup_limit_i)));
        end
    end

    always_comb begin
        win_d         = win_q;
        rx_win_endp_o = 1'b0;
        if (!link_en_i) begin
            win_d = WinClosed;
        end else if (win_size_i > HalfSlot) begin
            win_d = WinForced;
        end else begin
            case (win_q)
                // opens only in the slot preceding an RX slot; a coincident sync keeps it shut
                WinClosed: begin
                    if (p_1us_i && !sync_p_i && !clk_sum[1] && (us_q == LastUs - win_ext)) begin
                        win_d = WinOpen;
                    end
                end
                WinOpen: begin
                    if (sync_p_i || (p_1us_i && (us_q == SyncUs + win_ext))) begin
                        win_d         = WinClosed;
                        rx_win_endp_o = 1'b1;
                    end
                end
                default: win_d = WinClosed;
            endcase
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            en_q   <= 1'b0;
            us_q   <= '0;
            slot_q <= '0;
            sup_q  <= '0;
            lost_q <= 1'b0;
            win_q  <= WinClosed;
        end else begin
            en_q   <= link_en_i;
            us_q   <= us_d;
            slot_q <= slot_d;
            sup_q  <= sup_d;
            lost_q <= lost_d;
            win_q  <= win_d;
        end
    end

endmodule

// File: rtl/bt_multilink_clk.sv
// 1 us divider and native Bluetooth clock, fanned out to NLINK independent link timebases.
module bt_multilink_clk
    import bt_clk_pkg::*;
#(
    parameter int unsigned NLINK   = 2,
    parameter int unsigned DIV_1US = 6,
    parameter int unsigned SLOT_US = bt_clk_pkg::SLOT_US,
    parameter int unsigned SYNC_US = bt_clk_pkg::SYNC_US,
    parameter int unsigned WINW    = 9,
    parameter int unsigned SUPW    = 16
) (
    input  logic                 clk_6M,
    input  logic                 rstz,
    bt_multilink_clk_if.slave    bus
);

    localparam int unsigned     DivW   = (DIV_1US > 1) ? $clog2(DIV_1US) : 1;
    localparam logic [DivW-1:0] DivTop = DivW'(DIV_1US - 1);
    localparam logic [USW-1:0]  LastUs = USW'(SLOT_US - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [USW-1:0]  nus_q, nus_d;
    logic [CLKW-2:0] nslot_q, nslot_d;
    logic            p_1us;

    assign p_1us     = (div_q == DivTop);
    assign bus.p_1us = p_1us;
    assign bus.clkn  = {nslot_q, half_slot(nus_q, SLOT_US)};

    always_comb begin
        div_d   = p_1us ? '0 : div_q + DivW'(1);
        nus_d   = nus_q;
        nslot_d = nslot_q;
        if (p_1us) begin
            if (nus_q == LastUs) begin
                nus_d   = '0;
                nslot_d = nslot_q + (CLKW-1)'(1);
            end else begin
                nus_d = nus_q + USW'(1);
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            div_q   <= '0;
            nus_q   <= '0;
            nslot_q <= '0;
        end else begin
            div_q   <= div_d;
            nus_q   <= nus_d;
            nslot_q <= nslot_d;
        end
    end

    for (genvar g = 0; g < NLINK; g++) begin : g_link
        bt_link_timebase #(
            .SLOT_US (SLOT_US),
            .SYNC_US (SYNC_US),
            .WINW    (WINW),
            .SUPW    (SUPW)
        ) u_link (
            .clk_6M        (clk_6M),
            .rstz          (rstz),
            .p_1us_i       (p_1us),
            .link_en_i     (bus.link_en[g]),
            .offset_i      (bus.link_offset[g*CLKW +: CLKW]),
            .sync_p_i      (bus.sync_p[g]),
            .win_size_i    (bus.win_size[g*WINW +: WINW]),
            .sup_limit_i   (bus.sup_limit[g*SUPW +: SUPW]),
            .link_clk_o    (bus.link_clk[g*CLKW +: CLKW]),
            .us_cnt_o      (bus.us_cnt[g*USW +: USW]),
            .tx_endp_o     (bus.tx_endp[g]),
            .rx_endp_o     (bus.rx_endp[g]),
            .rx_win_o      (bus.rx_win[g]),
            .rx_win_endp_o (bus.rx_win_endp[g]),
            .link_lost_o   (bus.link_lost[g])
        );
    end

endmodule

// File: tb/tb_bt_multilink_clk.sv
// Directed bench for bt_multilink_clk: time-based reference model checked every cycle, plus literals.
module tb_bt_multilink_clk;

    localparam int NL   = 2;
    localparam int DIV  = 6;
    localparam int SLOT = 625;
    localparam int SYNC = 68;
    localparam int HALF = SLOT / 2;
    localparam int CW   = 28;
    localparam int WW   = 9;
    localparam int SW   = 16;
    localparam int UW   = 10;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference state: cycles since reset, link time as total us since link start
    longint m_n = 0;
    longint m_lt[NL];
    bit     m_en[NL];
    bit     m_open[NL];
    bit     m_forced[NL];
    int     m_miss[NL];
    bit     m_lost[NL];

    bt_multilink_clk_if #(.NLINK(NL), .WINW(WW), .SUPW(SW)) bus ();

    bt_multilink_clk #(
        .NLINK   (NL),
        .DIV_1US (DIV),
        .SLOT_US (SLOT),
        .SYNC_US (SYNC),
        .WINW    (WW),
        .SUPW    (SW)
    ) dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus)
    );

    always #5 clk_6M = ~clk_6M;

    function automatic void chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic bit e_p();
        return (m_n % DIV) == DIV - 1;
    endfunction

    function automatic logic [CW-1:0] e_clkn();
        longint t, v;
        t = m_n / DIV;
        v = (t / SLOT) * 2 + (((t % SLOT) >= HALF) ? 1 : 0);
        return v[CW-1:0];
    endfunction

    function automatic int e_us(input int l);
        return int'(m_lt[l] % SLOT);
    endfunction

    function automatic int e_win(input int l);
        return int'(bus.win_size[l*WW +: WW]);
    endfunction

    function automatic int e_lim(input int l);
        return int'(bus.sup_limit[l*SW +: SW]);
    endfunction

    function automatic logic [CW-1:0] e_raw(input int l);
        longint v;
        logic [CW-1:0] off;
        off = bus.link_offset[l*CW +: CW];
        v = (m_lt[l] / SLOT) * 2 + ((e_us(l) >= HALF) ? 1 : 0) + longint'(off & 28'hFFFFFFC);
        return v[CW-1:0];
    endfunction

    function automatic bit e_tx(input int l);
        logic [CW-1:0] r;
        r = e_raw(l);
        return e_p() && e_us(l) == SLOT - 1 && !r[1];
    endfunction

    function automatic bit e_rx(input int l);
        logic [CW-1:0] r;
        r = e_raw(l);
        return e_p() && e_us(l) == SLOT - 1 && r[1];
    endfunction

    function automatic bit e_close(input int l);
        return bus.link_en[l] && e_win(l) <= HALF && m_open[l] &&
               (bus.sync_p[l] || (e_p() && e_us(l) == SYNC + e_win(l)));
    endfunction

    function automatic bit e_open(input int l);
        logic [CW-1:0] r;
        r = e_raw(l);
        return e_p() && !bus.sync_p[l] && !r[1] && e_us(l) == SLOT - 1 - e_win(l);
    endfunction

    task automatic model_update();
        bit p, en, sy, rxe, cls, opn;
        int w, lim;
        if (!rstz) begin
            m_n = 0;
            for (int l = 0; l < NL; l++) begin
                m_lt[l] = 0; m_en[l] = 0; m_open[l] = 0; m_forced[l] = 0;
                m_miss[l] = 0; m_lost[l] = 0;
            end
            return;
        end
        p = e_p();
        for (int l = 0; l < NL; l++) begin
            en  = bus.link_en[l];
            sy  = bus.sync_p[l];
            w   = e_win(l);
            lim = e_lim(l);
            rxe = e_rx(l);
            cls = e_close(l);
            opn = e_open(l);
            if (!en || w > HALF || m_forced[l]) m_open[l] = 0;
            else if (m_open[l]) m_open[l] = !cls;
            else m_open[l] = opn;
            m_forced[l] = en && (w > HALF);
            if (!en || sy) begin
                m_miss[l] = 0;
                m_lost[l] = 0;
            end else begin
                if (rxe && !(lim != 0 && m_miss[l] >= lim)) m_miss[l]++;
                if (lim != 0 && m_miss[l] >= lim) m_lost[l] = 1;
            end
            if (!en) m_lt[l] = 0;
            else if (sy) m_lt[l] = (m_lt[l] / SLOT) * SLOT + SYNC + 1;
            else if (p) m_lt[l]++;
            m_en[l] = en;
        end
        m_n++;
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            m_lt[l] = 0; m_en[l] = 0; m_open[l] = 0; m_forced[l] = 0;
            m_miss[l] = 0; m_lost[l] = 0;
        end
        forever begin
            @(posedge clk_6M or negedge rstz);
            model_update();
        end
    end

    initial begin
        forever begin
            @(negedge clk_6M);
            chk("p_1us", longint'(bus.p_1us), longint'(e_p()));
            chk("clkn", longint'(bus.clkn), longint'(e_clkn()));
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("link_clk[%0d]", l), longint'(bus.link_clk[l*CW +: CW]),
                    m_en[l] ? longint'(e_raw(l)) : 0);
                chk($sformatf("us_cnt[%0d]", l), longint'(bus.us_cnt[l*UW +: UW]), e_us(l));
                chk($sformatf("tx_endp[%0d]", l), longint'(bus.tx_endp[l]), longint'(e_tx(l)));
                chk($sformatf("rx_endp[%0d]", l), longint'(bus.rx_endp[l]), longint'(e_rx(l)));
                chk($sformatf("rx_win[%0d]", l), longint'(bus.rx_win[l]),
                    longint'(m_open[l] || m_forced[l]));
                chk($sformatf("rx_win_endp[%0d]", l), longint'(bus.rx_win_endp[l]),
                    longint'(e_close(l)));
                chk($sformatf("link_lost[%0d]", l), longint'(bus.link_lost[l]),
                    longint'(m_lost[l]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_6M);
        #2;
    endtask

    // advance until link l is at the given slot (-1 = any) and us, optionally on a tick cycle
    task automatic run_to(input int l, input int slot, input int us, input bit need_p);
        for (int k = 0; k < 40000; k++) begin
            if ((slot < 0 || m_lt[l] / SLOT == slot) && e_us(l) == us && (!need_p || e_p()))
                return;
            step();
        end
        total++;
        bad++;
        $display("FAIL run_to timeout: link %0d slot %0d us %0d not reached", l, slot, us);
    endtask

    initial begin
        bus.link_en     = 2'b11;
        bus.link_offset = '0;
        bus.sync_p      = '0;
        bus.win_size    = {9'd20, 9'd20};
        bus.sup_limit   = {16'd3, 16'd0};
        repeat (3) step();
        rstz = 1'b1;
        #1;
        chk("reset_clkn", longint'(bus.clkn), 0);
        chk("reset_us0", longint'(bus.us_cnt[UW-1:0]), 0);
        chk("reset_p", longint'(bus.p_1us), 0);

        repeat (5) step();
        chk("first_tick", longint'(bus.p_1us), 1);
        step();
        chk("tick_one_cycle", longint'(bus.p_1us), 0);

        run_to(0, 0, HALF, 0);
        chk("clkn_half", longint'(bus.clkn), 1);
        chk("link_clk0_half", longint'(bus.link_clk[CW-1:0]), 1);

        run_to(0, 0, 604, 1);
        chk("win_before_open", longint'(bus.rx_win[0]), 0);
        step();
        chk("win_open", longint'(bus.rx_win[0]), 1);
        chk("us_605", longint'(bus.us_cnt[UW-1:0]), 605);

        run_to(0, 0, SLOT - 1, 1);
        chk("tx_endp0_slot0", longint'(bus.tx_endp[0]), 1);
        chk("rx_endp0_slot0", longint'(bus.rx_endp[0]), 0);
        step();
        chk("clkn_after_slot", longint'(bus.clkn), 2);
        chk("link_clk0_eq_clkn", longint'(bus.link_clk[CW-1:0]), 2);
        chk("win_open_into_rx", longint'(bus.rx_win[0]), 1);

        bus.link_offset[CW-1:0]    = 28'h13;
        bus.link_offset[2*CW-1:CW] = 28'h0ABCDEF0;
        #1;
        chk("offset0", longint'(bus.link_clk[CW-1:0]), 28'h12);
        chk("offset1", longint'(bus.link_clk[2*CW-1:CW]), 28'h0ABCDEF2);

        run_to(0, 1, SYNC + 20, 1);
        chk("win_endp_close", longint'(bus.rx_win_endp[0]), 1);
        step();
        chk("win_closed", longint'(bus.rx_win[0]), 0);
        chk("win_endp_once", longint'(bus.rx_win_endp[0]), 0);

        run_to(0, 1, SLOT - 1, 1);
        chk("rx_endp0_slot1", longint'(bus.rx_endp[0]), 1);
        chk("tx_endp0_slot1", longint'(bus.tx_endp[0]), 0);

        // sync outside the window: applied, window stays shut
        run_to(0, 2, 50, 0);
        bus.sync_p[0] = 1'b1;
        #1;
        chk("sync_out_no_endp", longint'(bus.rx_win_endp[0]), 0);
        step();
        bus.sync_p[0] = 1'b0;
        chk("sync_out_us", longint'(bus.us_cnt[UW-1:0]), SYNC + 1);
        chk("sync_out_win", longint'(bus.rx_win[0]), 0);

        run_to(0, 3, 50, 0);
        chk("win_open_slot3", longint'(bus.rx_win[0]), 1);
        bus.sync_p[0] = 1'b1;
        #1;
        chk("sync_in_endp", longint'(bus.rx_win_endp[0]), 1);
        step();
        bus.sync_p[0] = 1'b0;
        chk("sync_in_us", longint'(bus.us_cnt[UW-1:0]), SYNC + 1);
        chk("sync_in_closed", longint'(bus.rx_win[0]), 0);

        run_to(0, 3, 100, 1);
        bus.sync_p[0] = 1'b1;
        step();
        bus.sync_p[0] = 1'b0;
        chk("sync_on_tick_us", longint'(bus.us_cnt[UW-1:0]), SYNC + 1);

        bus.win_size[WW-1:0] = 9'd400;
        step();
        chk("forced_on", longint'(bus.rx_win[0]), 1);
        repeat (1200) step();
        chk("forced_held", longint'(bus.rx_win[0]), 1);
        bus.win_size[WW-1:0] = 9'd20;
        step();
        chk("forced_off", longint'(bus.rx_win[0]), 0);

        run_to(1, 5, SLOT - 1, 1);
        chk("rx_endp1_third", longint'(bus.rx_endp[1]), 1);
        chk("lost_before", longint'(bus.link_lost[1]), 0);
        step();
        chk("lost_set", longint'(bus.link_lost[1]), 1);

        run_to(1, 6, 50, 0);
        bus.sync_p[1] = 1'b1;
        step();
        bus.sync_p[1] = 1'b0;
        chk("lost_cleared", longint'(bus.link_lost[1]), 0);
        chk("sync1_us", longint'(bus.us_cnt[2*UW-1:UW]), SYNC + 1);

        run_to(1, 6, 610, 0);
        chk("win1_open", longint'(bus.rx_win[1]), 1);
        bus.link_en[1] = 1'b0;
        step();
        chk("drop_link_clk1", longint'(bus.link_clk[2*CW-1:CW]), 0);
        chk("drop_us1", longint'(bus.us_cnt[2*UW-1:UW]), 0);
        chk("drop_win1", longint'(bus.rx_win[1]), 0);
        chk("drop_lost1", longint'(bus.link_lost[1]), 0);
        repeat (60) step();
        bus.link_en[1] = 1'b1;
        repeat (200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
